difftest_commit_sched: RTL and testbench
========================================

// Module: difftest_commit_sched
// PURPOSE
//  Commit scheduler between WB retirement and the difftest DPI port. Buffers each retired
//  instruction's record {pc, instr, next_pc, skip} and issues records one per cycle over a
//  valid/ready handshake to the simulator-side checker.
//  Stalls WB when full and tracks end-of-program (ebreak).
//  Watchdog flags a pipeline that stops retiring. Sits after the WB stage, replacing direct
//  combinational gating of diff PC/instr; compiled only under `DIFFTEST.
// PARAMETERS
//  DEPTH           4     record slots; power of two, >=2
//  TIMEOUT_CYCLES  1024  consecutive cycles in RUN with no accepted commit before TIMEOUT
//  DW              `DATA_WIDTH  width of pc/instr/next_pc fields
// PORTS
//  clk           in   1         clock
//  rst           in   1         reset, asynchronous, active-high
//  wb_valid      in   1         instruction retires in WB this cycle
//  wb_pc         in   DW        retiring PC
//  wb_instr      in   DW        retiring instruction word
//  wb_next_pc    in   DW        PC of next instruction (hold-aware, from WB/ID select)
//  wb_skip       in   1         MMIO access; REF must skip rather than compare
//  wb_ebreak     in   1         retiring instruction is ebreak
//  commit_stall  out  1         queue full; WB must hold its record
//  diff_valid    out  1         head record available
//  diff_ready    in   1         checker consumes head this cycle
//  diff_pc       out  DW        head pc; 0 when !diff_valid
//  diff_instr    out  DW        head instr; 0 when !diff_valid
//  diff_next_pc  out  DW        head next_pc; 0 when !diff_valid
//  diff_skip     out  1         head skip; 0 when !diff_valid
//  halt          out  1         ebreak committed and queue drained
//  timeout       out  1         watchdog expired (sticky until reset)
//  commit_count  out  64        records handed to checker; wraps modulo 2^64
// BEHAVIOUR
//  - Reset (async): pointers, occupancy, watchdog, commit_count = 0; state RUN; all outputs 0.
//  - Push = wb_valid & !full & state==RUN. Pop = diff_valid & diff_ready.
//  - commit_stall = full & (state==RUN): registered occupancy only; no comb path from diff_ready.
//    Push+pop on a full queue: pop happens, push rejected, WB retries next cycle.
//  - Push+pop on a non-empty, non-full queue: both happen, occupancy unchanged.
//  - Latency: record pushed in cycle N is visible on diff_* in cycle N+1 at the earliest;
//    FIFO order strictly preserved. Pointers are log2(DEPTH)+1 bits and wrap naturally.
//  - diff_* driven from head slot, masked to 0 when empty.
//  - FSM: RUN -> DRAIN on a push with wb_ebreak=1 (the ebreak record itself is queued);
//    DRAIN: no pushes, wb_* ignored, commit_stall=0; -> HALT when queue is empty.
//    HALT: halt=1, terminal until reset.
//    RUN -> TIMEOUT when watchdog reaches TIMEOUT_CYCLES-1 with no push that cycle.
//    TIMEOUT: timeout=1, no pushes, queue still drains; terminal until reset.
//    ebreak push and watchdog expiry in the same cycle: push wins (-> DRAIN).
//  - Watchdog: clears on push, increments each RUN cycle without a push; frozen outside RUN.
//  - commit_count increments by 1 per pop, in every state.
// STRUCTURE
//  - define.v: `DT_REC_W (3*DW+1); state encodings DT_RUN/DT_DRAIN/DT_HALT/DT_TIMEOUT.
//  - One sub-module: difftest_fifo (sync FIFO; push/pop/full/empty/head; async-reset pointers).
//    Top holds the FSM, watchdog, counter and output masking.
// TESTING
//  1 Single: push pc=0x80000000 instr=0x00000413 -> next cycle diff_valid=1 with same fields;
//    ready=1 -> commit_count=1.
//  2 Fill: ready=0, 5 pushes with DEPTH=4 -> commit_stall=1 after 4th; 5th accepted
//    only after first pop; order pc 0x0,0x4,..,0x10.
//  3 Full + simultaneous push/pop -> pop taken, push rejected that cycle; no loss, no duplicates.
//  4 Ebreak at pc 0x8000000c with 2 queued -> DRAIN, later wb_valid ignored;
//    halt=1 the cycle after the 3rd pop.
//  5 TIMEOUT_CYCLES=16, no wb_valid -> timeout=1 after 16 cycles; queued records still drain.
//  6 Async rst mid-DRAIN with 3 queued -> diff_valid=0, halt=0, commit_count=0 before next clk edge.

Source files
------------

// File: rtl/difftest_commit_sched_pkg.sv
// Shared types and helpers for the difftest commit scheduler.
// Holds the FSM encoding and the record-width helper.
package difftest_commit_sched_pkg;

  typedef enum logic [1:0] {
    DT_RUN     = 2'd0,
    DT_DRAIN   = 2'd1,
    DT_HALT    = 2'd2,
    DT_TIMEOUT = 2'd3
  } dt_state_t;

  // A record is {pc, instr, next_pc, skip}.
  function automatic int dt_rec_w(input int dw);
    return 3 * dw + 1;
  endfunction

endpackage

// File: rtl/difftest_commit_sched_fifo.sv
// Synchronous record FIFO with wrap-bit pointers and asynchronously reset state.
// The head slot is read combinationally from the registered read pointer.
module difftest_commit_sched_fifo
  import difftest_commit_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 97
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Record storage; no reset needed since reads are masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer update; the extra top bit distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/difftest_commit_sched.sv
// Commit scheduler between WB retirement and the difftest checker port.
// Queues retired records, tracks ebreak drain/halt and a retirement watchdog.
module difftest_commit_sched
  import difftest_commit_sched_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DW             = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [DW-1:0] wb_pc,
  input  logic [DW-1:0] wb_instr,
  input  logic [DW-1:0] wb_next_pc,
  input  logic          wb_skip,
  input  logic          wb_ebreak,
  output logic          commit_stall,
  output logic          diff_valid,
  input  logic          diff_ready,
  output logic [DW-1:0] diff_pc,
  output logic [DW-1:0] diff_instr,
  output logic [DW-1:0] diff_next_pc,
  output logic          diff_skip,
  output logic          halt,
  output logic          timeout,
  output logic [63:0]   commit_count
);

  localparam int REC_W = dt_rec_w(DW);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  dt_state_t        state;
  logic [WD_W-1:0]  wd;
  logic [REC_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             last_pop;

  assign push     = wb_valid & ~full & (state == DT_RUN);
  assign pop      = ~empty & diff_ready;
  assign last_pop = pop & (count == {{(CNT_W-1){1'b0}}, 1'b1});

  difftest_commit_sched_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({wb_pc, wb_instr, wb_next_pc, wb_skip}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // FSM, watchdog and commit counter; an ebreak push beats watchdog expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DT_RUN;
      wd           <= '0;
      commit_count <= 64'd0;
    end else begin
      if (pop) commit_count <= commit_count + 64'd1;
      case (state)
        DT_RUN: begin
          if (push) begin
            wd <= '0;
            if (wb_ebreak) state <= DT_DRAIN;
          end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state <= DT_TIMEOUT;
          end else begin
            wd <= wd + {{(WD_W-1){1'b0}}, 1'b1};
          end
        end
        // Halt in the cycle right after the queue empties.
        DT_DRAIN: begin
          if (empty || last_pop) state <= DT_HALT;
        end
        DT_HALT:    state <= DT_HALT;
        DT_TIMEOUT: state <= DT_TIMEOUT;
        default:    state <= DT_RUN;
      endcase
    end
  end

  assign commit_stall = full & (state == DT_RUN);
  assign diff_valid   = ~empty;
  assign halt         = (state == DT_HALT);
  assign timeout      = (state == DT_TIMEOUT);
  assign {diff_pc, diff_instr, diff_next_pc, diff_skip} = diff_valid ? head : {REC_W{1'b0}};

endmodule

// File: tb/tb_difftest_commit_sched.sv
// Directed self-checking bench for difftest_commit_sched (DEPTH=4, TIMEOUT_CYCLES=16).
module tb_difftest_commit_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = 32'd0;
  logic [31:0] wb_instr = 32'd0;
  logic [31:0] wb_next_pc = 32'd0;
  logic        wb_skip = 1'b0;
  logic        wb_ebreak = 1'b0;
  logic        diff_ready = 1'b0;
  logic        commit_stall;
  logic        diff_valid;
  logic [31:0] diff_pc;
  logic [31:0] diff_instr;
  logic [31:0] diff_next_pc;
  logic        diff_skip;
  logic        halt;
  logic        timeout;
  logic [63:0] commit_count;

  int n_cmp = 0;
  int n_bad = 0;

  difftest_commit_sched #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (16),
    .DW             (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_pc        (wb_pc),
    .wb_instr     (wb_instr),
    .wb_next_pc   (wb_next_pc),
    .wb_skip      (wb_skip),
    .wb_ebreak    (wb_ebreak),
    .commit_stall (commit_stall),
    .diff_valid   (diff_valid),
    .diff_ready   (diff_ready),
    .diff_pc      (diff_pc),
    .diff_instr   (diff_instr),
    .diff_next_pc (diff_next_pc),
    .diff_skip    (diff_skip),
    .halt         (halt),
    .timeout      (timeout),
    .commit_count (commit_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic sk, input logic eb);
    wb_valid   = v;
    wb_pc      = pc;
    wb_instr   = pc ^ 32'h0000_0013;
    wb_next_pc = pc + 32'd4;
    wb_skip    = sk;
    wb_ebreak  = eb;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    diff_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_val("rst_valid", {63'd0, diff_valid}, 64'd0);
    check_val("rst_stall", {63'd0, commit_stall}, 64'd0);
    check_val("rst_halt", {63'd0, halt}, 64'd0);
    check_val("rst_timeout", {63'd0, timeout}, 64'd0);
    check_val("rst_count", commit_count, 64'd0);
    check_val("rst_pc", {32'd0, diff_pc}, 64'd0);

    // 1: single record
    wb_valid = 1'b1; wb_pc = 32'h8000_0000; wb_instr = 32'h0000_0413;
    wb_next_pc = 32'h8000_0004; wb_skip = 1'b1; wb_ebreak = 1'b0;
    step();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check_val("t1_valid", {63'd0, diff_valid}, 64'd1);
    check_val("t1_pc", {32'd0, diff_pc}, 64'h8000_0000);
    check_val("t1_instr", {32'd0, diff_instr}, 64'h0000_0413);
    check_val("t1_next", {32'd0, diff_next_pc}, 64'h8000_0004);
    check_val("t1_skip", {63'd0, diff_skip}, 64'd1);
    diff_ready = 1'b1;
    step();
    diff_ready = 1'b0;
    check_val("t1_count", commit_count, 64'd1);
    check_val("t1_empty", {63'd0, diff_valid}, 64'd0);
    check_val("t1_masked_instr", {32'd0, diff_instr}, 64'd0);

    // 2/3: fill, stall, simultaneous push+pop on full queue
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check_val("t2_stall_pre", {63'd0, commit_stall}, 64'd0);
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      step();
    end
    check_val("t2_stall_full", {63'd0, commit_stall}, 64'd1);
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    step();
    check_val("t2_still_full", {63'd0, commit_stall}, 64'd1);
    check_val("t2_head0", {32'd0, diff_pc}, 64'h0);
    diff_ready = 1'b1;
    step();
    diff_ready = 1'b0;
    check_val("t3_count", commit_count, 64'd1);
    check_val("t3_head4", {32'd0, diff_pc}, 64'h4);
    check_val("t3_stall_rel", {63'd0, commit_stall}, 64'd0);
    step();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check_val("t3_refull", {63'd0, commit_stall}, 64'd1);
    diff_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_val("t2_order", {32'd0, diff_pc}, 64'(i * 4));
      step();
    end
    diff_ready = 1'b0;
    check_val("t3_drained", {63'd0, diff_valid}, 64'd0);
    check_val("t3_total", commit_count, 64'd5);

    // 4: ebreak drain and halt
    do_reset();
    drive(1'b1, 32'h8000_0004, 1'b0, 1'b0); step();
    drive(1'b1, 32'h8000_0008, 1'b0, 1'b0); step();
    drive(1'b1, 32'h8000_000c, 1'b0, 1'b1); step();
    drive(1'b1, 32'h0000_dead, 1'b0, 1'b0);
    check_val("t4_no_stall", {63'd0, commit_stall}, 64'd0);
    step();
    diff_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check_val("t4_halt_pre", {63'd0, halt}, 64'd0);
      check_val("t4_order", {32'd0, diff_pc}, 64'(32'h8000_0000 + 32'(i * 4)));
      step();
    end
    check_val("t4_halt", {63'd0, halt}, 64'd1);
    check_val("t4_valid", {63'd0, diff_valid}, 64'd0);
    check_val("t4_count", commit_count, 64'd3);
    step();
    check_val("t4_ignored", {63'd0, diff_valid}, 64'd0);
    diff_ready = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);

    // 5: watchdog timeout, queue still drains
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 1'b0); step();
    drive(1'b1, 32'h104, 1'b0, 1'b0); step();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step();
    check_val("t5_timeout_pre", {63'd0, timeout}, 64'd0);
    step();
    check_val("t5_timeout", {63'd0, timeout}, 64'd1);
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    diff_ready = 1'b1;
    check_val("t5_head0", {32'd0, diff_pc}, 64'h100);
    step();
    check_val("t5_head1", {32'd0, diff_pc}, 64'h104);
    step();
    check_val("t5_drained", {63'd0, diff_valid}, 64'd0);
    check_val("t5_count", commit_count, 64'd2);
    check_val("t5_sticky", {63'd0, timeout}, 64'd1);
    diff_ready = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);

    // 6: asynchronous reset mid-drain
    do_reset();
    drive(1'b1, 32'h300, 1'b0, 1'b0); step();
    drive(1'b1, 32'h304, 1'b0, 1'b0); step();
    drive(1'b1, 32'h308, 1'b0, 1'b0); step();
    drive(1'b1, 32'h30c, 1'b0, 1'b1); step();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    diff_ready = 1'b1; step(); diff_ready = 1'b0;
    check_val("t6_pre_valid", {63'd0, diff_valid}, 64'd1);
    check_val("t6_pre_count", commit_count, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_valid", {63'd0, diff_valid}, 64'd0);
    check_val("t6_halt", {63'd0, halt}, 64'd0);
    check_val("t6_count", commit_count, 64'd0);
    check_val("t6_pc", {32'd0, diff_pc}, 64'd0);
    step();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
